// File: rtl/int_pkg.sv
// Shared constants for the interrupt controller: register map, CAUSE layout
// and FSM state encoding.
package int_pkg;

    localparam logic [1:0] REG_PEND  = 2'd0;
    localparam logic [1:0] REG_MASK  = 2'd1;
    localparam logic [1:0] REG_CAUSE = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    localparam int CAUSE_VALID_BIT = 31;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// N-wide two-flop synchronizer followed by a previous-value flop; emits a
// one-cycle rise pulse per source on each synchronized 0->1 transition.
module irq_sync_edge #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] i_irq,
    output logic [N-1:0] o_rise
);

    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;
    logic [N-1:0] r_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage capture the old value of the one before it, forming a real shift chain.
            r_sync1 <= i_irq;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: latches device edges into PEND, masks and arbitrates
// lowest-id-first, and handshakes INT with the CPU via int_ack / int_eret.
module int_ctrl
    import int_pkg::*;
#(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             sel,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic             int_ack,
    input  logic             int_eret,
    output logic             INT
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [N_IRQ-1:0]   r_pend;
    logic [N_IRQ-1:0]   r_mask;
    logic               r_en;
    logic [ID_W-1:0]    r_cur_id;
    logic               r_int;

    logic [N_IRQ-1:0]   w_rise;
    logic [N_IRQ-1:0]   w_elig;
    logic [N_IRQ-1:0]   w_cur_1h;
    logic [N_IRQ-1:0]   w_pend_clr;
    logic [ID_W-1:0]    w_sel_id;
    logic               w_wr;
    logic               w_cur_elig;
    logic               w_ack_take;
    logic               w_unused_wdata;

    irq_sync_edge #(.N(N_IRQ)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_irq  (irq_in),
        .o_rise (w_rise)
    );

    assign w_wr           = sel & we;
    assign w_elig         = r_pend & r_mask & {N_IRQ{r_en}};
    assign w_unused_wdata = ^wdata[31:N_IRQ];

    // Descending scan so the lowest eligible index is the last one written.
    always_comb begin
        // NOTE: every output gets a default first so this block stays purely combinational (no latch).
        w_sel_id = '0;
        w_cur_1h = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) w_sel_id = ID_W'(i);
            w_cur_1h[i] = (r_cur_id == ID_W'(i));
        end
    end

    assign w_cur_elig = |(w_elig & w_cur_1h);
    assign w_ack_take = (r_state == REQ) & int_ack;
    assign w_pend_clr = ((w_wr && addr == REG_PEND) ? wdata[N_IRQ-1:0] : '0)
                      | (w_ack_take ? w_cur_1h : '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|w_elig) w_state_nxt = REQ;
            REQ:     if (int_ack) w_state_nxt = SERVICE;
                     else if (!w_cur_elig) w_state_nxt = IDLE;
            SERVICE: if (int_eret) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_int   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_int   <= (w_state_nxt == REQ);
        end
    end

    // A same-cycle rise overrides any clear, so no edge is ever lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend   <= '0;
            r_mask   <= '0;
            r_en     <= 1'b0;
            r_cur_id <= '0;
        end else begin
            r_pend <= (r_pend & ~w_pend_clr) | w_rise;
            if (r_state == IDLE && |w_elig) r_cur_id <= w_sel_id;
            if (w_wr && addr == REG_MASK) r_mask <= wdata[N_IRQ-1:0];
            if (w_wr && addr == REG_CTRL) r_en <= wdata[0];
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            REG_PEND:  rdata[N_IRQ-1:0] = r_pend;
            REG_MASK:  rdata[N_IRQ-1:0] = r_mask;
            REG_CAUSE: begin
                rdata[CAUSE_VALID_BIT] = (r_state == SERVICE);
                rdata[ID_W-1:0]        = r_cur_id;
            end
            REG_CTRL:  rdata[0] = r_en;
            default:   rdata = '0;
        endcase
    end

    assign INT = r_int;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: table-driven register reads plus
// hand-written sequences for arbitration, handshake and reset corner cases.
module tb_int_ctrl;
    import int_pkg::*;

    localparam int N_IRQ = 8;
    localparam int ID_W  = 5;

    logic             clk      = 1'b0;
    logic             reset    = 1'b0;
    logic [N_IRQ-1:0] irq_in   = '0;
    logic             sel      = 1'b0;
    logic             we       = 1'b0;
    logic [1:0]       addr     = 2'd0;
    logic [31:0]      wdata    = '0;
    logic [31:0]      rdata;
    logic             int_ack  = 1'b0;
    logic             int_eret = 1'b0;
    logic             int_out;

    typedef struct {
        string       name;
        logic [1:0]  addr;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    vec_t clr_tbl[4];
    sb_t  sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int_ctrl #(.N_IRQ(N_IRQ), .ID_W(ID_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .irq_in   (irq_in),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .int_ack  (int_ack),
        .int_eret (int_eret),
        .INT      (int_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        sb_t e;
        sb_q.push_back('{name, exp});
        addr = a;
        #1;
        e = sb_q.pop_front();
        check(e.name, rdata, e.exp);
    endtask

    task automatic chk_int(input string name, input logic exp);
        check(name, {31'b0, int_out}, {31'b0, exp});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic pulse_irq(input logic [N_IRQ-1:0] m);
        irq_in = m;
        tick();
        irq_in = '0;
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic eret();
        int_eret = 1'b1;
        tick();
        int_eret = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_tbl[0] = '{"clr_pend",  REG_PEND,  32'h0};
        clr_tbl[1] = '{"clr_mask",  REG_MASK,  32'h0};
        clr_tbl[2] = '{"clr_cause", REG_CAUSE, 32'h0};
        clr_tbl[3] = '{"clr_ctrl",  REG_CTRL,  32'h0};

        // 1: reset with all requests high, then masked latching
        reset  = 1'b0;
        irq_in = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk_int("rst_int", 1'b0);
        for (int i = 0; i < 4; i++) rd_chk(clr_tbl[i].name, clr_tbl[i].addr, clr_tbl[i].exp);
        reset = 1'b1;
        tick();
        tick();
        rd_chk("pend_edge2", REG_PEND, 32'h0);
        tick();
        rd_chk("pend_edge3", REG_PEND, 32'hFF);
        chk_int("masked_int_a", 1'b0);
        tick();
        tick();
        chk_int("masked_int_b", 1'b0);
        irq_in = '0;
        wr(REG_PEND, 32'hFF);
        rd_chk("w1c_all", REG_PEND, 32'h0);

        // 2: two pending, lowest id wins, back-to-back after eret
        wr(REG_MASK, 32'h0C);
        rd_chk("mask_rb", REG_MASK, 32'h0C);
        pulse_irq(8'h08);
        pulse_irq(8'h04);
        tick();
        tick();
        tick();
        rd_chk("pend_2_3", REG_PEND, 32'h0C);
        chk_int("en_off_int", 1'b0);
        wr(REG_CTRL, 32'h1);
        rd_chk("ctrl_rb", REG_CTRL, 32'h1);
        chk_int("int_latency0", 1'b0);
        tick();
        chk_int("int_req2", 1'b1);
        rd_chk("cause_req2", REG_CAUSE, 32'h0000_0002);
        ack();
        chk_int("int_after_ack", 1'b0);
        rd_chk("cause_svc2", REG_CAUSE, 32'h8000_0002);
        rd_chk("pend_after_ack", REG_PEND, 32'h08);
        tick();
        chk_int("svc_hold", 1'b0);
        eret();
        chk_int("eret_plus1", 1'b0);
        tick();
        chk_int("eret_plus2", 1'b1);
        rd_chk("cause_req3", REG_CAUSE, 32'h0000_0003);
        ack();
        rd_chk("cause_svc3", REG_CAUSE, 32'h8000_0003);
        rd_chk("pend_empty", REG_PEND, 32'h0);
        eret();
        tick();
        chk_int("idle_empty", 1'b0);

        // 3: withdrawal by masking while in REQ
        pulse_irq(8'h04);
        tick();
        tick();
        chk_int("wd_pre", 1'b0);
        tick();
        chk_int("wd_req", 1'b1);
        wr(REG_MASK, 32'h0);
        chk_int("wd_mask_edge", 1'b1);
        tick();
        chk_int("wd_dropped", 1'b0);
        rd_chk("wd_pend_kept", REG_PEND, 32'h04);
        rd_chk("wd_cause", REG_CAUSE, 32'h0000_0002);
        tick();
        chk_int("wd_idle", 1'b0);
        wr(REG_PEND, 32'h04);
        wr(REG_MASK, 32'hFF);

        // 4: no nesting while in SERVICE
        pulse_irq(8'h04);
        tick();
        tick();
        tick();
        chk_int("nest_req2", 1'b1);
        ack();
        rd_chk("nest_pend0", REG_PEND, 32'h0);
        pulse_irq(8'h01);
        tick();
        tick();
        rd_chk("nest_pend1", REG_PEND, 32'h01);
        chk_int("nest_int_a", 1'b0);
        tick();
        tick();
        chk_int("nest_int_b", 1'b0);
        eret();
        chk_int("nest_eret1", 1'b0);
        tick();
        chk_int("nest_eret2", 1'b1);
        rd_chk("nest_cause_req", REG_CAUSE, 32'h0000_0000);
        ack();
        rd_chk("nest_cause_svc", REG_CAUSE, 32'h8000_0000);
        eret();
        tick();

        // 5: set beats W1C; ack beats eret in REQ
        pulse_irq(8'h20);
        tick();
        wr(REG_PEND, 32'h20);
        rd_chk("set_wins", REG_PEND, 32'h20);
        chk_int("sw_idle", 1'b0);
        tick();
        chk_int("sw_req5", 1'b1);
        rd_chk("sw_cause_req", REG_CAUSE, 32'h0000_0005);
        int_ack  = 1'b1;
        int_eret = 1'b1;
        tick();
        int_ack  = 1'b0;
        int_eret = 1'b0;
        chk_int("ae_int", 1'b0);
        rd_chk("ae_cause", REG_CAUSE, 32'h8000_0005);
        tick();
        rd_chk("ae_cause_hold", REG_CAUSE, 32'h8000_0005);
        rd_chk("ae_pend", REG_PEND, 32'h0);

        // 6: asynchronous reset in SERVICE
        tick();
        #3;
        reset = 1'b0;
        #1;
        chk_int("arst_int", 1'b0);
        for (int i = 0; i < 4; i++) rd_chk({"arst_", clr_tbl[i].name}, clr_tbl[i].addr, clr_tbl[i].exp);
        @(posedge clk);
        #3;
        reset = 1'b1;
        wr(REG_MASK, 32'hFF);
        wr(REG_CTRL, 32'h1);
        repeat (4) tick();
        chk_int("post_rst_quiet", 1'b0);
        rd_chk("post_rst_pend", REG_PEND, 32'h0);
        pulse_irq(8'h02);
        tick();
        tick();
        tick();
        chk_int("post_rst_new", 1'b1);
        rd_chk("post_rst_cause", REG_CAUSE, 32'h0000_0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
